// File: rtl/count_sequence_checker.sv
// count_sequence_checker
//   Receive-side monitor for a free-running binary counter. Each valid
//   sample is compared with the registered expected next value (+1 or -1
//   mod 2^WIDTH, chosen by dir at the sample edge). The block locks after
//   LOCK_LEN consecutive correct steps. While locked it flags breaks on
//   err, counts them in a saturating err_count, and counts wrap-around
//   steps in wrap_count.
//
//   Optional build macro: COUNT_CHECK_STICKY_ERR_EN
//     defined   -> err sets on the first sequence break and holds until reset
//     undefined -> err is a one-cycle pulse per sequence break
module count_sequence_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_LEN = 2,
  parameter int unsigned CNTW     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  input  logic             dir,
  output logic [WIDTH-1:0] expected,
  output logic             locked,
  output logic             err,
  output logic [CNTW-1:0]  err_count,
  output logic [CNTW-1:0]  wrap_count
);

  localparam int unsigned MW = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [MW-1:0]    match_q, match_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  errc_q, errc_d;
  logic [CNTW-1:0]  wrapc_q, wrapc_d;

  logic [WIDTH-1:0] nxt_val;
  logic [MW-1:0]    match_inc;
  logic             hit;
  logic             wrap_step;
  logic             brk;

  // Next expected value, match test and wrap detection for the current sample
  always_comb begin
    nxt_val   = dir ? (count_in - WIDTH'(1)) : (count_in + WIDTH'(1));
    hit       = (count_in == expected_q);
    wrap_step = dir ? (count_in == '1) : (count_in == '0);
    match_inc = match_q + MW'(1);
  end

  // Next-state and datapath update; nothing moves on edges without count_valid
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    match_d    = match_q;
    errc_d     = errc_q;
    wrapc_d    = wrapc_q;
    brk        = 1'b0;

    if (count_valid) begin
      // Every valid sample reloads expected, so a break re-seeds from the new value
      expected_d = nxt_val;
      unique case (state_q)
        IDLE: begin
          match_d = '0;
          state_d = ACQ;
        end
        ACQ: begin
          if (hit) begin
            match_d = match_inc;
            if (match_inc == LOCK_M) begin
              state_d = LOCKED;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            if (wrap_step) begin
              wrapc_d = wrapc_q + CNTW'(1);
            end
          end else begin
            brk     = 1'b1;
            match_d = '0;
            state_d = ACQ;
            if (errc_q != '1) begin
              errc_d = errc_q + CNTW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          match_d = '0;
        end
      endcase
    end

`ifdef COUNT_CHECK_STICKY_ERR_EN
    err_d = err_q | brk;
`else
    err_d = brk;
`endif
  end

  // State and datapath registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      expected_q <= '0;
      match_q    <= '0;
      err_q      <= 1'b0;
      errc_q     <= '0;
      wrapc_q    <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      match_q    <= match_d;
      err_q      <= err_d;
      errc_q     <= errc_d;
      wrapc_q    <= wrapc_d;
    end
  end

  assign expected   = expected_q;
  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign err_count  = errc_q;
  assign wrap_count = wrapc_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed testbench for count_sequence_checker: a vector table for the
// main sequences plus hand-written saturation and async-reset sequences.
module tb_count_sequence_checker;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       count_valid;
  logic       dir;

  logic [3:0] expected;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic [7:0] wrap_count;

  logic [3:0] s_expected;
  logic       s_locked;
  logic       s_err;
  logic [1:0] s_err_count;
  logic [1:0] s_wrap_count;

  int unsigned tests = 0;
  int unsigned fails = 0;

  count_sequence_checker #(.WIDTH(4), .LOCK_LEN(2), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
    .dir(dir), .expected(expected), .locked(locked), .err(err),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  count_sequence_checker #(.WIDTH(4), .LOCK_LEN(2), .CNTW(2)) dut_s (
    .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
    .dir(dir), .expected(s_expected), .locked(s_locked), .err(s_err),
    .err_count(s_err_count), .wrap_count(s_wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          valid;
    bit          dr;
    logic [3:0]  cnt;
    logic [3:0]  e_exp;
    bit          e_lk;
    bit          e_err;
    int unsigned e_ec;
    int unsigned e_wc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_main(input string tag, input logic [3:0] e_exp, input bit e_lk,
                            input bit e_err, input int unsigned e_ec, input int unsigned e_wc);
    check({tag, ".expected"},   32'(expected),   32'(e_exp));
    check({tag, ".locked"},     32'(locked),     32'(e_lk));
    check({tag, ".err"},        32'(err),        32'(e_err));
    check({tag, ".err_count"},  32'(err_count),  e_ec);
    check({tag, ".wrap_count"}, 32'(wrap_count), e_wc);
  endtask

  task automatic add(input bit r, input bit v, input bit d, input int c, input int e,
                     input bit lk, input bit er, input int unsigned ec, input int unsigned wc);
    vec_t t;
    t.rst = r; t.valid = v; t.dr = d; t.cnt = 4'(c); t.e_exp = 4'(e);
    t.e_lk = lk; t.e_err = er; t.e_ec = ec; t.e_wc = wc;
    tbl.push_back(t);
  endtask

  task automatic step(input bit v, input bit d, input logic [3:0] c);
    @(negedge clk);
    count_valid = v;
    dir         = d;
    count_in    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    count_valid = 1'b0;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; count_valid = 1'b0; dir = 1'b0; count_in = '0;
    #3;
    check_main("por", 4'd0, 1'b0, 1'b0, 0, 0);
    reset = 1'b0;

    //  rst v  d  cnt exp lk err ec wc
    // lock up-count 3,4,5
    add(0, 1, 0,  3,  4, 0, 0, 0, 0);
    add(0, 1, 0,  4,  5, 0, 0, 0, 0);
    add(0, 1, 0,  5,  6, 1, 0, 0, 0);
    // break with 9, then relock on 10,11
    add(0, 1, 0,  9, 10, 0, 1, 1, 0);
    add(0, 1, 0, 10, 11, 0, 0, 1, 0);
    add(0, 1, 0, 11, 12, 1, 0, 1, 0);
    // up-count wrap through 15 -> 0
    add(0, 1, 0, 12, 13, 1, 0, 1, 0);
    add(0, 1, 0, 13, 14, 1, 0, 1, 0);
    add(0, 1, 0, 14, 15, 1, 0, 1, 0);
    add(0, 1, 0, 15,  0, 1, 0, 1, 0);
    add(0, 1, 0,  0,  1, 1, 0, 1, 1);
    add(0, 1, 0,  1,  2, 1, 0, 1, 1);
    // held value is a break
    add(0, 1, 0,  1,  2, 0, 1, 2, 1);
    // idle cycle with junk on the bus clears the pulse only
    add(0, 0, 1,  7,  2, 0, 0, 2, 1);
    // relock, then reverse direction
    add(0, 1, 0,  2,  3, 0, 0, 2, 1);
    add(0, 1, 0,  3,  4, 1, 0, 2, 1);
    add(0, 1, 1,  2,  1, 0, 1, 3, 1);
    // fresh start: down-count with gaps, wrap 0 -> 15
    add(1, 0, 0,  0,  0, 0, 0, 0, 0);
    add(0, 1, 1,  2,  1, 0, 0, 0, 0);
    add(0, 0, 0,  9,  1, 0, 0, 0, 0);
    add(0, 1, 1,  1,  0, 0, 0, 0, 0);
    add(0, 0, 0,  9,  0, 0, 0, 0, 0);
    add(0, 1, 1,  0, 15, 1, 0, 0, 0);
    add(0, 0, 0,  9, 15, 1, 0, 0, 0);
    add(0, 1, 1, 15, 14, 1, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        step(tbl[i].valid, tbl[i].dr, tbl[i].cnt);
      end
      check_main($sformatf("vec%0d", i), tbl[i].e_exp, tbl[i].e_lk, tbl[i].e_err,
                 tbl[i].e_ec, tbl[i].e_wc);
    end

    // Saturation on the CNTW=2 instance: five lock/break cycles
    begin
      logic [3:0] last;
      logic [3:0] bv;
      do_reset();
      step(1, 0, 4'd0);
      step(1, 0, 4'd1);
      step(1, 0, 4'd2);
      check("sat.lock0", 32'(s_locked), 32'd1);
      last = 4'd2;
      for (int k = 1; k <= 5; k++) begin
        bv = last + 4'd5;
        step(1, 0, bv);
        check($sformatf("sat%0d.err", k), 32'(s_err), 32'd1);
        check($sformatf("sat%0d.err_count", k), 32'(s_err_count), (k > 3) ? 32'd3 : 32'(k));
        step(1, 0, bv + 4'd1);
        check($sformatf("sat%0d.err_clr", k), 32'(s_err), 32'd0);
        step(1, 0, bv + 4'd2);
        check($sformatf("sat%0d.relock", k), 32'(s_locked), 32'd1);
        last = bv + 4'd2;
      end
    end

    // Async reset while locked with wrap_count=2
    do_reset();
    step(1, 0, 4'd13);
    step(1, 0, 4'd14);
    step(1, 0, 4'd15);
    check("ar.lock", 32'(locked), 32'd1);
    step(1, 0, 4'd0);
    for (int v = 1; v <= 15; v++) step(1, 0, 4'(v));
    step(1, 0, 4'd0);
    check("ar.wrap2", 32'(wrap_count), 32'd2);
    check("ar.locked_pre", 32'(locked), 32'd1);
    @(negedge clk);
    count_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_main("ar.async", 4'd0, 1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    step(1, 0, 4'd7);
    check_main("ar.first", 4'd8, 1'b0, 1'b0, 0, 0);
    step(1, 0, 4'd8);
    check("ar.acq1", 32'(locked), 32'd0);
    step(1, 0, 4'd9);
    check("ar.relock", 32'(locked), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
